arith_op_pipe: RTL and testbench

//  Parametrised, pipelined successor of the small adder/mux arithmetic submodules.
//  One datapath executes four operations, selected per transaction by op_i:
//    - scaled add
//    - multiply-add
//    - threshold-conditional add/xor
//    - flag-selected add
//  Two register stages with valid/ready flow control; sits between operand source and result sink.

---
 rtl/arith_op_pipe.sv | 116 +++++++++++
 tb/tb_arith_op_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_op_pipe.sv
// Two-stage valid/ready arithmetic pipeline: scaled add, multiply-add,
// threshold add/xor and flag-selected add, with a completed-transfer counter.
module arith_op_pipe #(
  parameter int unsigned W      = 4,
  parameter int unsigned THRESH = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     c_i,
  input  logic             cin_i,
  input  logic [2:0]       x_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W+1:0]     res_o,
  output logic             ovf_o,
  output logic [1:0]       op_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned MW = 2 * W + 2;  // holds 3*b*c exactly
  localparam int unsigned RW = 2 * W + 3;  // holds a + 3*b*c exactly
  localparam int unsigned OW = W + 2;

  logic          adv1;
  logic          adv2;
  logic          s1_valid;
  logic [1:0]    s1_op;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [W-1:0]  s1_c;
  logic          s1_cin;
  logic [2:0]    s1_x;
  logic [MW-1:0] s1_mul;
  logic          sel3;
  logic [RW-1:0] r_exact;
  logic [OW-1:0] res_d;
  logic          ovf_d;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  // Stage 1: operand capture and the product term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_cin   <= 1'b0;
      s1_x     <= '0;
      s1_mul   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op_i;
        s1_a   <= a_i;
        s1_b   <= b_i;
        s1_c   <= c_i;
        s1_cin <= cin_i;
        s1_x   <= x_i;
        s1_mul <= MW'(b_i) * MW'(c_i) * MW'(3);
      end
    end
  end

  // Exact result first; truncation and overflow are derived from it.
  always_comb begin
    r_exact = '0;
    sel3    = s1_x[0] | (~s1_x[1] & s1_x[2]);
    case (s1_op)
      2'd0: r_exact = (RW'(s1_a) << 1) + RW'(s1_b) + RW'(s1_cin);
      2'd1: r_exact = RW'(s1_a) + RW'(s1_mul);
      2'd2: r_exact = (s1_b > W'(THRESH)) ? RW'(s1_a) + RW'(s1_c)
                                          : RW'(s1_a ^ s1_c);
      default: r_exact = sel3 ? RW'(s1_a) + RW'(s1_b)
                              : RW'(s1_b) + RW'(s1_c);
    endcase
    res_d = (s1_op == 2'd0) ? r_exact[OW-1:0] : OW'(r_exact[W-1:0]);
    ovf_d = |r_exact[RW-1:W];
  end

  // Stage 2: output registers, held while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_o     <= '0;
      ovf_o     <= 1'b0;
      op_o      <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res_o <= res_d;
        ovf_o <= ovf_d;
        op_o  <= s1_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (out_valid & out_ready) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arith_op_pipe.sv
// Randomized and directed bench for arith_op_pipe against a queue-based
// transaction model; a second instance exercises a 3-bit counter wrap.
module tb_arith_op_pipe;

  localparam int unsigned W      = 4;
  localparam int unsigned THRESH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] c_i = '0;
  logic         cin_i = 1'b0;
  logic [2:0]   x_i = '0;

  logic         in_ready, out_valid, ovf_o;
  logic [W+1:0] res_o;
  logic [1:0]   op_o;
  logic [7:0]   cnt_o;
  logic         in_ready3, out_valid3, ovf3;
  logic [W+1:0] res3;
  logic [1:0]   op3;
  logic [2:0]   cnt3;

  always #5 clk = ~clk;

  arith_op_pipe #(.W(W), .THRESH(THRESH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .cin_i(cin_i), .x_i(x_i),
    .out_valid(out_valid), .out_ready(out_ready), .res_o(res_o),
    .ovf_o(ovf_o), .op_o(op_o), .cnt_o(cnt_o)
  );

  arith_op_pipe #(.W(W), .THRESH(THRESH), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .cin_i(cin_i), .x_i(x_i),
    .out_valid(out_valid3), .out_ready(out_ready), .res_o(res3),
    .ovf_o(ovf3), .op_o(op3), .cnt_o(cnt3)
  );

  typedef struct {
    int res;
    int ovf;
    int op;
    int cap;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   cnt_m = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic exp_t model(input int op, input int a, input int b,
                                 input int c, input int cin, input int x);
    exp_t e;
    int   r;
    int   s;
    case (op)
      0: r = 2 * a + b + cin;
      1: r = a + 3 * b * c;
      2: r = (b > THRESH) ? a + c : a ^ c;
      default: begin
        s = ((x & 1) != 0) || (((x & 2) == 0) && ((x & 4) != 0)) ? 1 : 0;
        r = (s != 0) ? a + b : b + c;
      end
    endcase
    e.ovf = (r >= (1 << W)) ? 1 : 0;
    e.res = (op == 0) ? r : r % (1 << W);
    e.op  = op;
    e.cap = 0;
    return e;
  endfunction

  // One clock: called at a falling edge, checks, drives, books, returns at next falling edge.
  task automatic cycle(input logic iv, input int op, input int a, input int b,
                       input int c, input int cin, input int x,
                       input logic ordy, output logic acc);
    logic ev;
    logic eir;
    exp_t e;
    ev = (q.size() > 0) && (edge_cnt > q[0].cap);
    check("out_valid", out_valid, ev);
    check("out_valid3", out_valid3, ev);
    if (ev) begin
      check("res", res_o, q[0].res);
      check("ovf", ovf_o, q[0].ovf);
      check("op", op_o, q[0].op);
      check("res3", res3, q[0].res);
    end
    check("cnt", cnt_o, cnt_m % 256);
    check("cnt3", cnt3, cnt_m % 8);
    rst_n     = 1'b1;
    in_valid  = iv;
    op_i      = 2'(op);
    a_i       = W'(a);
    b_i       = W'(b);
    c_i       = W'(c);
    cin_i     = 1'(cin);
    x_i       = 3'(x);
    out_ready = ordy;
    #1;
    eir = !((q.size() == 2) && !ordy);
    check("in_ready", in_ready, eir);
    check("in_ready3", in_ready3, eir);
    if (ev && ordy) begin
      void'(q.pop_front());
      cnt_m++;
    end
    acc = iv && eir;
    if (acc) begin
      e = model(op, a, b, c, cin, x);
      e.cap = edge_cnt + 1;
      q.push_back(e);
    end
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy, output logic acc);
    cycle(iv, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7), ordy, acc);
  endtask

  // Reset with a transaction offered; nothing may survive it.
  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    op_i      = 2'($urandom_range(0, 3));
    a_i       = W'($urandom_range(0, 15));
    b_i       = W'($urandom_range(0, 15));
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    q.delete();
    cnt_m = 0;
    edge_cnt++;
    check("rst_valid", out_valid, 0);
    check("rst_res", res_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_op", op_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_cnt3", cnt3, 0);
  endtask

  task automatic directed(input int op, input int a, input int b, input int c,
                          input int cin, input int x, input int er, input int eo);
    logic acc;
    cycle(1'b1, op, a, b, c, cin, x, 1'b1, acc);
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, acc);
    check("dir_valid", out_valid, 1);
    check("dir_res", res_o, er);
    check("dir_ovf", ovf_o, eo);
    check("dir_op", op_o, op);
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   k;
    int   cyc;
    int   low_seen;

    @(negedge clk);
    apply_reset();

    directed(0, 15, 15, 0, 1, 0, 46, 1);
    directed(1, 1, 3, 5, 0, 0, 14, 1);
    directed(2, 6, 2, 3, 0, 0, 5, 0);
    directed(2, 9, 3, 9, 0, 0, 2, 1);
    directed(3, 1, 2, 4, 0, 3'b100, 3, 0);
    directed(3, 1, 2, 4, 0, 3'b110, 6, 0);

    // Five back-to-back transactions with the sink stalled for four cycles.
    apply_reset();
    k = 0;
    cyc = 0;
    low_seen = 0;
    while ((k < 5 || q.size() > 0) && cyc < 40) begin
      rnd_cycle(k < 5, !(cyc >= 3 && cyc <= 6), acc);
      if (!in_ready) low_seen++;
      if (acc) k++;
      cyc++;
    end
    check("bp_stalled", (low_seen > 0) ? 1 : 0, 1);
    check("bp_cnt", cnt_o, 5);
    check("bp_cnt3", cnt3, 5);

    // Nine transfers wrap the 3-bit counter to 1.
    apply_reset();
    k = 0;
    cyc = 0;
    while ((k < 9 || q.size() > 0) && cyc < 40) begin
      rnd_cycle(k < 9, 1'b1, acc);
      if (acc) k++;
      cyc++;
    end
    check("wrap_cnt", cnt_o, 9);
    check("wrap_cnt3", cnt3, 1);

    // Random traffic with a mid-stream reset; long enough to wrap the 8-bit counter.
    apply_reset();
    for (int i = 0; i < 1400; i++) begin
      if (i == 700) apply_reset();
      rnd_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, acc);
    end
    for (int i = 0; i < 10; i++) rnd_cycle(1'b0, 1'b1, acc);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
